// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoded control, operands, immediate,
// funct bits and register addresses from ID into EX. Adds a valid bit,
// hold for load-use stalls, bubble insertion on redirect, and saturating
// stall/flush event counters for performance debug.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int FUNCT_W = 10,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               cnt_clr_i,
    input  logic               valid_i,
    input  logic               RegWrite_i,
    input  logic               MemToReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               ALUSrc_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic [DATA_W-1:0]  Readdata1_i,
    input  logic [DATA_W-1:0]  Readdata2_i,
    input  logic [DATA_W-1:0]  Imm_i,
    input  logic [FUNCT_W-1:0] ALU_i,
    input  logic [REG_AW-1:0]  Rd_i,
    input  logic [REG_AW-1:0]  Rs1_i,
    input  logic [REG_AW-1:0]  Rs2_i,
    output logic               valid_o,
    output logic               RegWrite_o,
    output logic               MemToReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               ALUSrc_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [DATA_W-1:0]  Readdata1_o,
    output logic [DATA_W-1:0]  Readdata2_o,
    output logic [DATA_W-1:0]  Imm_o,
    output logic [FUNCT_W-1:0] ALU_o,
    output logic [REG_AW-1:0]  Rd_o,
    output logic [REG_AW-1:0]  Rs1_o,
    output logic [REG_AW-1:0]  Rs2_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A stall only counts when no flush overrides it in the same cycle.
    logic stall_eff;
    assign stall_eff = stall_i & ~flush_i;

    // Pipeline fields: reset and flush both insert an all-zero bubble (Rd=0
    // keeps forwarding harmless); stall holds; otherwise load. Side-effect
    // controls are gated by valid_i so an invalid slot can never write.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_o     <= 1'b0;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            MemRead_o   <= 1'b0;
            MemWrite_o  <= 1'b0;
            ALUSrc_o    <= 1'b0;
            ALUOp_o     <= '0;
            Readdata1_o <= '0;
            Readdata2_o <= '0;
            Imm_o       <= '0;
            ALU_o       <= '0;
            Rd_o        <= '0;
            Rs1_o       <= '0;
            Rs2_o       <= '0;
        end else if (!stall_i) begin
            valid_o     <= valid_i;
            RegWrite_o  <= RegWrite_i & valid_i;
            MemToReg_o  <= MemToReg_i & valid_i;
            MemRead_o   <= MemRead_i  & valid_i;
            MemWrite_o  <= MemWrite_i & valid_i;
            ALUSrc_o    <= ALUSrc_i;
            ALUOp_o     <= ALUOp_i;
            Readdata1_o <= Readdata1_i;
            Readdata2_o <= Readdata2_i;
            Imm_o       <= Imm_i;
            ALU_o       <= ALU_i;
            Rd_o        <= Rd_i;
            Rs1_o       <= Rs1_i;
            Rs2_o       <= Rs2_i;
        end
    end

    // Saturating event counters; clear beats increment, reset beats clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_eff && stall_cnt_o != CNT_MAX)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_i && flush_cnt_o != CNT_MAX)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg, built with a 4-bit counter width so
// saturation is reachable in a few cycles.
module tb_id_ex_stage_reg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int FUNCT_W = 10;
    localparam int ALUOP_W = 2;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst, stall, flush, cnt_clr, valid;
    logic reg_write, mem_to_reg, mem_read, mem_write, alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  rd1, rd2, imm;
    logic [FUNCT_W-1:0] funct;
    logic [REG_AW-1:0]  rd, rs1, rs2;

    logic v_o, rw_o, m2r_o, mr_o, mw_o, as_o;
    logic [ALUOP_W-1:0] op_o;
    logic [DATA_W-1:0]  rd1_o, rd2_o, imm_o;
    logic [FUNCT_W-1:0] funct_o;
    logic [REG_AW-1:0]  rd_o, rs1_o, rs2_o;
    logic [CNT_W-1:0]   scnt, fcnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .FUNCT_W(FUNCT_W),
        .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .cnt_clr_i(cnt_clr), .valid_i(valid),
        .RegWrite_i(reg_write), .MemToReg_i(mem_to_reg), .MemRead_i(mem_read),
        .MemWrite_i(mem_write), .ALUSrc_i(alu_src), .ALUOp_i(alu_op),
        .Readdata1_i(rd1), .Readdata2_i(rd2), .Imm_i(imm), .ALU_i(funct),
        .Rd_i(rd), .Rs1_i(rs1), .Rs2_i(rs2),
        .valid_o(v_o), .RegWrite_o(rw_o), .MemToReg_o(m2r_o), .MemRead_o(mr_o),
        .MemWrite_o(mw_o), .ALUSrc_o(as_o), .ALUOp_o(op_o),
        .Readdata1_o(rd1_o), .Readdata2_o(rd2_o), .Imm_o(imm_o), .ALU_o(funct_o),
        .Rd_o(rd_o), .Rs1_o(rs1_o), .Rs2_o(rs2_o),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every output zero, as after reset or a fresh bubble.
    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(v_o), 0);
        chk({tag, ".ctrl"}, {26'd0, rw_o, m2r_o, mr_o, mw_o, as_o, 1'b0}, 0);
        chk({tag, ".aluop"}, 32'(op_o), 0);
        chk({tag, ".rd1"}, rd1_o, 0);
        chk({tag, ".rd2"}, rd2_o, 0);
        chk({tag, ".imm"}, imm_o, 0);
        chk({tag, ".funct"}, 32'(funct_o), 0);
        chk({tag, ".regs"}, {17'd0, rd_o, rs1_o, rs2_o}, 0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        valid = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; alu_src = 1'b0; alu_op = '0;
        rd1 = 32'hDEADBEEF; rd2 = '0; imm = '0; funct = 10'h2A5;
        rd = 5'd7; rs1 = 5'd3; rs2 = 5'd4;

        // Reset for two cycles overrides live inputs.
        tick(); tick();
        chk_all_zero("reset");
        chk("reset.scnt", 32'(scnt), 0);
        chk("reset.fcnt", 32'(fcnt), 0);

        // Release: first instruction appears one edge later.
        rst = 1'b0;
        tick();
        chk("load.valid", 32'(v_o), 1);
        chk("load.regwrite", 32'(rw_o), 1);
        chk("load.rd1", rd1_o, 32'hDEADBEEF);
        chk("load.rd", 32'(rd_o), 7);
        chk("load.funct", 32'(funct_o), 32'h2A5);
        chk("load.rs", {rs1_o, rs2_o}, {5'd3, 5'd4});

        // Invalid slot: side-effect controls masked, data/ALUSrc/ALUOp not.
        valid = 1'b0; mem_write = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
        mem_read = 1'b1; imm = 32'h10; alu_src = 1'b1; alu_op = 2'd2;
        tick();
        chk("inv.valid", 32'(v_o), 0);
        chk("inv.memwrite", 32'(mw_o), 0);
        chk("inv.regwrite", 32'(rw_o), 0);
        chk("inv.m2r_mr", {m2r_o, mr_o}, 0);
        chk("inv.imm", imm_o, 32'h10);
        chk("inv.alusrc", 32'(as_o), 1);
        chk("inv.aluop", 32'(op_o), 2);

        // Instruction A, then a 3-cycle stall with changed inputs.
        valid = 1'b1; reg_write = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0;
        mem_read = 1'b1; rd2 = 32'h1234; rd = 5'd9;
        tick();
        chk("a.rd2", rd2_o, 32'h1234);
        chk("a.memread", 32'(mr_o), 1);
        stall = 1'b1; rd2 = 32'h5678; valid = 1'b0; rd = 5'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.rd2", i), rd2_o, 32'h1234);
            chk($sformatf("stall%0d.valid", i), 32'(v_o), 1);
            chk($sformatf("stall%0d.rd", i), 32'(rd_o), 9);
        end
        chk("stall.scnt", 32'(scnt), 3);
        stall = 1'b0; valid = 1'b1; rd = 5'd9;
        tick();
        chk("release.rd2", rd2_o, 32'h5678);
        chk("release.memread", 32'(mr_o), 1);

        // Stall and flush together: flush wins, counts only as flush.
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_all_zero("flushstall");
        chk("flushstall.fcnt", 32'(fcnt), 1);
        chk("flushstall.scnt", 32'(scnt), 3);

        // Flush alone lasts exactly one cycle.
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("reload.valid", 32'(v_o), 1);
        flush = 1'b1;
        tick();
        chk("flush.valid", 32'(v_o), 0);
        chk("flush.rd", 32'(rd_o), 0);
        flush = 1'b0;
        tick();
        chk("postflush.valid", 32'(v_o), 1);
        chk("postflush.rd", 32'(rd_o), 9);
        chk("postflush.fcnt", 32'(fcnt), 2);

        // Clear counters; pipeline contents untouched.
        cnt_clr = 1'b1;
        tick();
        chk("clr.scnt", 32'(scnt), 0);
        chk("clr.fcnt", 32'(fcnt), 0);
        chk("clr.rd2", rd2_o, 32'h5678);
        cnt_clr = 1'b0;

        // Saturation: 20 stall cycles on a 4-bit counter.
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat14.scnt", 32'(scnt), 14);
            if (i == 15) chk("sat15.scnt", 32'(scnt), 15);
        end
        chk("sat20.scnt", 32'(scnt), 15);
        chk("sat.valid_held", 32'(v_o), 1);
        chk("sat.rd2_held", rd2_o, 32'h5678);

        // One flush to make flush_cnt nonzero, then clear beats increment.
        flush = 1'b1;
        tick();
        chk("preclr.fcnt", 32'(fcnt), 1);
        chk("preclr.scnt", 32'(scnt), 15);
        flush = 1'b0; cnt_clr = 1'b1;
        tick();
        chk("clrsat.scnt", 32'(scnt), 0);
        chk("clrsat.fcnt", 32'(fcnt), 0);
        cnt_clr = 1'b0;

        // Reset in the middle of a stall that is holding valid data.
        stall = 1'b0; valid = 1'b1; reg_write = 1'b1; rd1 = 32'hCAFE0001;
        tick();
        chk("mid.rd1", rd1_o, 32'hCAFE0001);
        stall = 1'b1;
        tick();
        chk("mid.scnt", 32'(scnt), 1);
        chk("mid.valid", 32'(v_o), 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        chk("midrst.scnt", 32'(scnt), 0);
        chk("midrst.fcnt", 32'(fcnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
